// File: rtl/game_of_life_top_if.sv
// ============================================================================
// Module      : game_of_life_top_if
// Description : Control, programming-button and display bundle for the
//               Game of Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_of_life_top_if #(
    parameter int ROWS = 7,
    parameter int COLS = 7
);
    logic                   in_stop;
    logic                   in_prgm;
    logic                   in_pp;
    logic                   in_btn0;
    logic                   in_btn1;
    logic [1:0]             out_game_state;
    logic [ROWS*COLS-1:0]   out_grid;

    modport master (
        output in_stop, in_prgm, in_pp, in_btn0, in_btn1,
        input  out_game_state, out_grid
    );

    modport slave (
        input  in_stop, in_prgm, in_pp, in_btn0, in_btn1,
        output out_game_state, out_grid
    );
endinterface

`default_nettype wire

// File: rtl/game_of_life_top.sv
// ============================================================================
// Module      : game_of_life_top
// Description : ROWSxCOLS Conway Game of Life engine with serial cell
//               programming and stop/program/play/pause control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_of_life_top #(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  wire logic           in_clka,
    input  wire logic           in_rst_n,
    game_of_life_top_if.slave   bus
);

    localparam int N     = ROWS * COLS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC    = COLS + 2;
    localparam int PR    = ROWS + 2;
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(N - 1);

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_PROGRAM = 2'b01,
        ST_PLAY    = 2'b10,
        ST_PAUSE   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       grid_q, grid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               pp_q;
    logic               pp_rise;
    logic [N-1:0]       next_gen;
    logic [PR*PC-1:0]   pad;

    assign pp_rise = bus.in_pp & ~pp_q;

    // Dead border ring around the grid so edge cells see no wrap-around.
    always_comb begin
        pad = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pad[(r + 1) * PC + (c + 1)] = grid_q[r * COLS + c];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int P = (r + 1) * PC + (c + 1);
            logic [3:0] nbr_cnt;

            assign nbr_cnt = 4'(pad[P - PC - 1]) + 4'(pad[P - PC]) + 4'(pad[P - PC + 1])
                           + 4'(pad[P - 1])                        + 4'(pad[P + 1])
                           + 4'(pad[P + PC - 1]) + 4'(pad[P + PC]) + 4'(pad[P + PC + 1]);

            assign next_gen[r * COLS + c] = (nbr_cnt == 4'd3) |
                                            (grid_q[r * COLS + c] & (nbr_cnt == 4'd2));
        end
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        ptr_d   = ptr_q;

        if (bus.in_stop) begin
            state_d = ST_STOP;
            grid_d  = '0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    if (bus.in_prgm) begin
                        state_d = ST_PROGRAM;
                        ptr_d   = '0;
                    end
                end
                ST_PROGRAM: begin
                    if (pp_rise) begin
                        state_d = ST_PLAY;
                    end else if (bus.in_btn0 ^ bus.in_btn1) begin
                        grid_d[ptr_q] = bus.in_btn1;
                        ptr_d         = (ptr_q == C_PTR_LAST) ? '0 : ptr_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (pp_rise) begin
                        state_d = ST_PAUSE;
                    end else begin
                        grid_d = next_gen;
                    end
                end
                ST_PAUSE: begin
                    // Play takes precedence; re-programming keeps the frozen grid.
                    if (pp_rise) begin
                        state_d = ST_PLAY;
                    end else if (bus.in_prgm) begin
                        state_d = ST_PROGRAM;
                        ptr_d   = '0;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge in_clka) begin
        if (!in_rst_n) begin
            state_q <= ST_STOP;
            grid_q  <= '0;
            ptr_q   <= '0;
            pp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            ptr_q   <= ptr_d;
            pp_q    <= bus.in_pp;
        end
    end

    assign bus.out_game_state = state_q;
    assign bus.out_grid       = grid_q;

endmodule

`default_nettype wire

// File: tb/tb_game_of_life_top.sv
// ============================================================================
// Module      : tb_game_of_life_top
// Description : Directed self-checking bench for the 7x7 Game of Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_of_life_top;

    localparam int ROWS = 7;
    localparam int COLS = 7;

    localparam logic [63:0] C_PAT   = 64'h0000_0000_0000_0CBE;
    localparam logic [63:0] C_PAT12 = 64'h0000_0000_0000_1CBE;
    localparam logic [63:0] C_HORIZ = (64'd1 << 23) | (64'd1 << 24) | (64'd1 << 25);
    localparam logic [63:0] C_VERT  = (64'd1 << 17) | (64'd1 << 24) | (64'd1 << 31);
    localparam logic [63:0] C_ALL   = (64'd1 << 49) - 64'd1;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    game_of_life_top_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    game_of_life_top #(.ROWS(ROWS), .COLS(COLS)) dut (
        .in_clka  (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic btn(input logic b0, input logic b1, input int n);
        bus.in_btn0 = b0;
        bus.in_btn1 = b1;
        step(n);
        bus.in_btn0 = 1'b0;
        bus.in_btn1 = 1'b0;
    endtask

    function automatic logic [63:0] st();
        return 64'(bus.out_game_state);
    endfunction

    function automatic logic [63:0] gr();
        return 64'(bus.out_grid);
    endfunction

    initial begin
        logic [4:0] rnd;
        tests  = 0;
        failed = 0;

        // Reset with random control inputs
        rst_n = 1'b0;
        rnd   = 5'($urandom);
        {bus.in_stop, bus.in_prgm, bus.in_pp, bus.in_btn0, bus.in_btn1} = rnd;
        step(2);
        check("reset_state", st(), 64'd0);
        check("reset_grid", gr(), 64'd0);
        {bus.in_stop, bus.in_prgm, bus.in_pp, bus.in_btn0, bus.in_btn1} = 5'b0;
        rst_n = 1'b1;

        // Stop, then program the 12-cell pattern
        bus.in_stop = 1'b1;
        step(2);
        bus.in_stop = 1'b0;
        check("stop_state", st(), 64'd0);
        bus.in_prgm = 1'b1;
        step(2);
        bus.in_prgm = 1'b0;
        check("program_state", st(), 64'd1);
        btn(1, 0, 1);
        btn(0, 1, 5);
        btn(1, 0, 1);
        btn(0, 1, 1);
        btn(1, 0, 2);
        btn(0, 1, 2);
        check("pattern_grid", gr(), C_PAT);
        btn(0, 1, 1);
        check("pointer_at_12", gr(), C_PAT12);

        // Stop clears; buttons and pp ignored in STOP
        bus.in_stop = 1'b1;
        step(1);
        bus.in_stop = 1'b0;
        check("stop_clear_state", st(), 64'd0);
        check("stop_clear_grid", gr(), 64'd0);
        btn(0, 1, 1);
        check("btn_ignored_stop", gr(), 64'd0);
        bus.in_pp = 1'b1;
        step(1);
        bus.in_pp = 1'b0;
        step(1);
        check("pp_ignored_stop", st(), 64'd0);

        // Blinker
        bus.in_prgm = 1'b1;
        step(1);
        bus.in_prgm = 1'b0;
        check("reprogram_state", st(), 64'd1);
        btn(1, 0, 23);
        btn(0, 1, 3);
        check("blinker_load", gr(), C_HORIZ);
        bus.in_pp = 1'b1;
        step(1);
        bus.in_pp = 1'b0;
        check("play_state", st(), 64'd2);
        check("play_entry_hold", gr(), C_HORIZ);
        step(1);
        check("gen1_vertical", gr(), C_VERT);
        step(1);
        check("gen2_horizontal", gr(), C_HORIZ);

        // Held pp gives one toggle
        bus.in_pp = 1'b1;
        step(1);
        check("pause_state", st(), 64'd3);
        check("pause_grid", gr(), C_HORIZ);
        step(2);
        check("pause_held_state", st(), 64'd3);
        check("pause_held_grid", gr(), C_HORIZ);
        bus.in_pp = 1'b0;
        step(1);
        check("pause_frozen", gr(), C_HORIZ);
        bus.in_pp = 1'b1;
        step(1);
        bus.in_pp = 1'b0;
        check("resume_state", st(), 64'd2);
        check("resume_hold", gr(), C_HORIZ);
        step(1);
        check("resume_evolve", gr(), C_VERT);

        // Pause then reprogram keeps the grid
        bus.in_pp = 1'b1;
        step(1);
        bus.in_pp = 1'b0;
        bus.in_prgm = 1'b1;
        step(1);
        bus.in_prgm = 1'b0;
        check("pause_to_program", st(), 64'd1);
        check("program_retains", gr(), C_VERT);

        // Pointer wrap
        btn(0, 1, 50);
        check("wrap_all_ones", gr(), C_ALL);
        btn(1, 1, 1);
        check("both_buttons_nop", gr(), C_ALL);
        btn(1, 0, 1);
        check("pointer_wrapped_1", gr(), C_ALL & ~64'd2);

        // Stop mid-play
        bus.in_pp = 1'b1;
        step(1);
        bus.in_pp = 1'b0;
        check("play_again", st(), 64'd2);
        step(1);
        bus.in_stop = 1'b1;
        step(1);
        bus.in_stop = 1'b0;
        check("midplay_stop_state", st(), 64'd0);
        check("midplay_stop_grid", gr(), 64'd0);
        for (int i = 0; i < 2; i++) begin
            bus.in_pp = 1'b1;
            step(1);
            bus.in_pp = 1'b0;
            step(1);
        end
        check("pp_after_stop_state", st(), 64'd0);
        check("pp_after_stop_grid", gr(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
